// File: rtl/matmul_op_sequencer.sv
// rtl/matmul_op_sequencer.sv - head/row/col/inner loop sequencer for the MAC datapath
// Issues one A/B operand pair per handshake and tracks C write-backs still in flight.
module matmul_op_sequencer #(
   parameter int ADDR_W  = 32,
   parameter int DIM_W   = 16,
   parameter int HEAD_W  = 4,
   parameter int MAX_OUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DIM_W-1:0]  cfg_m,
   input  logic [DIM_W-1:0]  cfg_n,
   input  logic [DIM_W-1:0]  cfg_k,
   input  logic [HEAD_W-1:0] cfg_heads,
   input  logic [ADDR_W-1:0] cfg_base_a,
   input  logic [ADDR_W-1:0] cfg_base_b,
   input  logic [ADDR_W-1:0] cfg_base_c,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [ADDR_W-1:0] op_a_addr,
   output logic [ADDR_W-1:0] op_b_addr,
   output logic [ADDR_W-1:0] op_c_addr,
   output logic              op_first,
   output logic              op_last,
   input  logic              wb_ack,
   output logic              busy,
   output logic              done,
   output logic              err_cfg,
   output logic              aborted
);

   localparam int OUT_W = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t state, state_nxt;

   logic [DIM_W-1:0]  m_r, n_r, k_r;
   logic [HEAD_W-1:0] heads_r;
   logic [HEAD_W-1:0] h_idx;
   logic [DIM_W-1:0]  i_idx, j_idx, k_idx;
   logic [ADDR_W-1:0] a_ptr, a_row;
   logic [ADDR_W-1:0] b_ptr, b_col, b_head;
   logic [ADDR_W-1:0] c_ptr;
   logic [OUT_W-1:0]  out_cnt, out_nxt;
   logic              err_cfg_r, aborted_r;

   logic cfg_ok, in_issue, last_k, last_j, last_i, last_h, final_op;
   logic throttle, xfer, out_inc, out_dec, abort_acc, start_acc;

   always_comb begin
      cfg_ok    = (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0) && (cfg_heads != '0);
      in_issue  = (state == S_ISSUE);
      last_k    = (k_idx == k_r - DIM_W'(1));
      last_j    = (j_idx == n_r - DIM_W'(1));
      last_i    = (i_idx == m_r - DIM_W'(1));
      last_h    = (h_idx == heads_r - HEAD_W'(1));
      final_op  = last_k && last_j && last_i && last_h;
      // An op_last op would push one more result in flight; hold it back at the limit.
      throttle  = last_k && (out_cnt == OUT_W'(MAX_OUT));
      op_valid  = in_issue && !throttle;
      xfer      = op_valid && op_ready;
      out_inc   = xfer && last_k;
      out_dec   = wb_ack && (out_cnt != '0);
      abort_acc = abort && ((state == S_ISSUE) || (state == S_DRAIN));
      start_acc = (state == S_IDLE) && start && cfg_ok;

      out_nxt = out_cnt;
      if (out_inc && !out_dec) begin
         out_nxt = out_cnt + OUT_W'(1);
      end else if (!out_inc && out_dec) begin
         out_nxt = out_cnt - OUT_W'(1);
      end
   end

   always_comb begin
      op_a_addr = in_issue ? a_ptr : '0;
      op_b_addr = in_issue ? b_ptr : '0;
      op_c_addr = in_issue ? c_ptr : '0;
      op_first  = in_issue && (k_idx == '0);
      op_last   = in_issue && last_k;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      err_cfg   = err_cfg_r;
      aborted   = aborted_r;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start_acc) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (xfer && final_op) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (out_nxt == '0) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         m_r       <= '0;
         n_r       <= '0;
         k_r       <= '0;
         heads_r   <= '0;
         h_idx     <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         k_idx     <= '0;
         a_ptr     <= '0;
         a_row     <= '0;
         b_ptr     <= '0;
         b_col     <= '0;
         b_head    <= '0;
         c_ptr     <= '0;
         out_cnt   <= '0;
         err_cfg_r <= 1'b0;
         aborted_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_cfg_r <= (state == S_IDLE) && start && !cfg_ok;
         aborted_r <= abort_acc;
         out_cnt   <= abort_acc ? '0 : out_nxt;

         if (start_acc) begin
            m_r     <= cfg_m;
            n_r     <= cfg_n;
            k_r     <= cfg_k;
            heads_r <= cfg_heads;
            h_idx   <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            k_idx   <= '0;
            a_ptr   <= cfg_base_a;
            a_row   <= cfg_base_a;
            b_ptr   <= cfg_base_b;
            b_col   <= cfg_base_b;
            b_head  <= cfg_base_b;
            c_ptr   <= cfg_base_c;
         end else if (xfer) begin
            if (!last_k) begin
               k_idx <= k_idx + DIM_W'(1);
               a_ptr <= a_ptr + ADDR_W'(1);
               b_ptr <= b_ptr + ADDR_W'(n_r);
            end else begin
               k_idx <= '0;
               c_ptr <= c_ptr + ADDR_W'(1);
               if (!last_j) begin
                  j_idx <= j_idx + DIM_W'(1);
                  a_ptr <= a_row;
                  b_col <= b_col + ADDR_W'(1);
                  b_ptr <= b_col + ADDR_W'(1);
               end else begin
                  // Row and head bases are contiguous: the next one starts right after the last word used.
                  j_idx <= '0;
                  a_row <= a_ptr + ADDR_W'(1);
                  a_ptr <= a_ptr + ADDR_W'(1);
                  if (!last_i) begin
                     i_idx <= i_idx + DIM_W'(1);
                     b_col <= b_head;
                     b_ptr <= b_head;
                  end else begin
                     i_idx  <= '0;
                     h_idx  <= h_idx + HEAD_W'(1);
                     b_head <= b_ptr + ADDR_W'(1);
                     b_col  <= b_ptr + ADDR_W'(1);
                     b_ptr  <= b_ptr + ADDR_W'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_matmul_op_sequencer.sv
// tb/tb_matmul_op_sequencer.sv - scoreboard bench for matmul_op_sequencer
module tb_matmul_op_sequencer;

   localparam int ADDR_W  = 32;
   localparam int DIM_W   = 16;
   localparam int HEAD_W  = 4;
   localparam int MAX_OUT = 2;
   localparam int ACK_DLY = 2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        first;
      logic        last;
   } op_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [DIM_W-1:0]  cfg_m = '0, cfg_n = '0, cfg_k = '0;
   logic [HEAD_W-1:0] cfg_heads = '0;
   logic [ADDR_W-1:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
   logic              op_valid;
   logic              op_ready = 1'b1;
   logic [ADDR_W-1:0] op_a_addr, op_b_addr, op_c_addr;
   logic              op_first, op_last;
   logic              wb_ack = 1'b0;
   logic              busy, done, err_cfg, aborted;

   int   total_cnt = 0;
   int   bad_cnt = 0;
   int   cyc = 0;
   op_t  exp_q[$];
   int   ack_q[$];
   int   out_m = 0;
   int   xfer_cnt = 0;
   int   ack_cnt = 0;
   int   sim_cnt = 0;
   int   first_x = 0, last_x = 0, last_ack = 0;
   logic job_on = 1'b0;
   logic ack_hold = 1'b0;
   logic ready_mode = 1'b0;

   matmul_op_sequencer #(
      .ADDR_W(ADDR_W), .DIM_W(DIM_W), .HEAD_W(HEAD_W), .MAX_OUT(MAX_OUT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_heads(cfg_heads),
      .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a_addr(op_a_addr), .op_b_addr(op_b_addr), .op_c_addr(op_c_addr),
      .op_first(op_first), .op_last(op_last), .wb_ack(wb_ack),
      .busy(busy), .done(done), .err_cfg(err_cfg), .aborted(aborted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Ready/ack driver after each rising edge, scoreboard monitor on the falling edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         op_ready = ready_mode ? ~op_ready : 1'b1;
         wb_ack = 1'b0;
         if (job_on && !ack_hold && ack_q.size() > 0) begin
            if (ack_q[0] <= cyc) begin
               wb_ack = 1'b1;
               void'(ack_q.pop_front());
            end
         end
         @(negedge clk);
         if (job_on) begin
            op_t  e;
            logic ev;
            logic xl;
            xl = 1'b0;
            ev = (exp_q.size() > 0) && !(exp_q[0].last && out_m == MAX_OUT);
            check("op_valid", 128'(op_valid), 128'(ev));
            if (op_valid && exp_q.size() > 0) begin
               e = exp_q[0];
               check("op", 128'({op_a_addr, op_b_addr, op_c_addr & {32{e.last}}, op_first, op_last}), 128'(e));
               if (op_ready) begin
                  void'(exp_q.pop_front());
                  if (xfer_cnt == 0) first_x = cyc;
                  last_x = cyc;
                  xfer_cnt++;
                  if (e.last) begin
                     xl = 1'b1;
                     ack_q.push_back(cyc + ACK_DLY);
                  end
               end
            end
            if (wb_ack) begin
               ack_cnt++;
               last_ack = cyc;
            end
            if (xl && wb_ack) sim_cnt++;
            if (xl && !(wb_ack && out_m > 0)) out_m++;
            else if (!xl && wb_ack && out_m > 0) out_m--;
         end
      end
   end

   task automatic flush();
      exp_q.delete();
      ack_q.delete();
      out_m = 0;
      xfer_cnt = 0;
      ack_cnt = 0;
      sim_cnt = 0;
   endtask

   task automatic start_job(input int m, input int n, input int k, input int h,
                            input int ba, input int bb, input int bc);
      op_t e;
      flush();
      cfg_m = DIM_W'(m);
      cfg_n = DIM_W'(n);
      cfg_k = DIM_W'(k);
      cfg_heads = HEAD_W'(h);
      cfg_base_a = ba;
      cfg_base_b = bb;
      cfg_base_c = bc;
      for (int hh = 0; hh < h; hh++)
         for (int ii = 0; ii < m; ii++)
            for (int jj = 0; jj < n; jj++)
               for (int kk = 0; kk < k; kk++) begin
                  e.a = ba + hh * m * k + ii * k + kk;
                  e.b = bb + hh * k * n + kk * n + jj;
                  e.last = (kk == k - 1);
                  e.first = (kk == 0);
                  e.c = e.last ? (bc + hh * m * n + ii * n + jj) : 32'd0;
                  exp_q.push_back(e);
               end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      job_on = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int ops, input int acks);
      int t;
      for (t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (done) break;
      end
      check({tag, "_done_seen"}, 128'(done), 128'(1));
      check({tag, "_xfers"}, 128'(xfer_cnt), 128'(ops));
      check({tag, "_acks"}, 128'(ack_cnt), 128'(acks));
      check({tag, "_done_after_ack"}, 128'(cyc - last_ack), 128'(1));
      @(posedge clk); #1;
      job_on = 1'b0;
      check({tag, "_idle"}, 128'({done, busy}), 128'(0));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_outs", 128'({op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last,
                                busy, done, err_cfg, aborted}), 128'(0));

      // 2x2x2 single head, back to back
      start_job(2, 2, 2, 1, 'h000, 'h100, 'h200);
      wait_done("t1", 8, 4);
      check("t1_b2b", 128'(last_x - first_x), 128'(7));

      // K=1, two heads
      start_job(1, 1, 1, 2, 'h0, 'h10, 'h20);
      wait_done("t2", 2, 2);

      // toggling ready
      ready_mode = 1'b1;
      start_job(2, 2, 2, 1, 'h000, 'h100, 'h200);
      wait_done("t3", 8, 4);
      ready_mode = 1'b0;

      // outstanding throttle
      ack_hold = 1'b1;
      start_job(1, 4, 1, 1, 'h40, 'h80, 'hc0);
      repeat (18) @(posedge clk);
      #1;
      check("t4_held_xfers", 128'(xfer_cnt), 128'(2));
      check("t4_held_valid", 128'(op_valid), 128'(0));
      ack_hold = 1'b0;
      wait_done("t4", 4, 4);
      check("t4_simul", 128'(sim_cnt != 0), 128'(1));

      // zero dimension
      cfg_k = '0;
      cfg_m = 16'd2; cfg_n = 16'd2; cfg_heads = 4'd1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t5_err", 128'({err_cfg, busy, op_valid}), 128'(3'b100));
      @(posedge clk); #1;
      check("t5_err_once", 128'({err_cfg, busy, op_valid}), 128'(0));

      // abort after 10 ops
      start_job(4, 4, 4, 1, 'h1000, 'h2000, 'h3000);
      for (int t = 0; t < 200; t++) begin
         @(posedge clk); #1;
         if (xfer_cnt >= 10) break;
      end
      check("t6_reached10", 128'(xfer_cnt >= 10), 128'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      job_on = 1'b0;
      check("t6_aborted", 128'({aborted, busy, done, op_valid}), 128'(4'b1000));
      @(posedge clk); #1;
      check("t6_after", 128'({aborted, busy, done, op_valid}), 128'(0));
      start_job(2, 2, 2, 1, 'h000, 'h100, 'h200);
      wait_done("t6_rerun", 8, 4);

      // reset mid-job
      start_job(4, 4, 4, 1, 'h1000, 'h2000, 'h3000);
      repeat (5) @(posedge clk);
      #1;
      job_on = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("t6_reset", 128'({op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last,
                              busy, done, err_cfg, aborted}), 128'(0));
      reset = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
